mac_accumulator: RTL and testbench

Downstream stage of the sequential signed multiplier in the MAC datapath. Observes the same `start` pulse the multiplier receives, captures each finished product when `mul_ready` returns high, and adds it with saturation into a signed accumulator. After `NTERMS` products it presents the dot-product result with a one-cycle `done` pulse, then auto-clears for the next sequence. A watchdog flags a multiplier that never finishes.

---
 rtl/mac_pkg.sv | 26 ++
 rtl/mac_accumulator_if.sv | 31 +++
 rtl/mac_accumulator_sat_add.sv | 29 ++
 rtl/mac_accumulator.sv | 129 ++++++++++++
 tb/tb_mac_accumulator.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and width/limit helpers for the MAC accumulator family.
package mac_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mac_state_t;

  function automatic int acc_width(input int opsize, input int guard);
    return 2 * opsize + guard;
  endfunction

  function automatic int cnt_width(input int nterms);
    return (nterms <= 2) ? 1 : $clog2(nterms);
  endfunction

  // Limits are returned 64 bits wide; callers cast down to their own width.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Multiplier-side handshake plus accumulator status bundle.
interface mac_accumulator_if #(
  parameter int OPSIZE = 8,
  parameter int NTERMS = 4,
  parameter int GUARD  = 4
);
  localparam int ACCW = mac_pkg::acc_width(OPSIZE, GUARD);
  localparam int CW   = mac_pkg::cnt_width(NTERMS);

  logic                     clr;
  logic                     start;
  logic                     mul_ready;
  logic signed [2*OPSIZE-1:0] mul_out;
  logic signed [ACCW-1:0]   acc_out;
  logic signed [ACCW-1:0]   result;
  logic                     done;
  logic [CW-1:0]            term_cnt;
  logic                     busy;
  logic                     ovf;
  logic                     err;

  modport master (
    output clr, start, mul_ready, mul_out,
    input  acc_out, result, done, term_cnt, busy, ovf, err
  );

  modport slave (
    input  clr, start, mul_ready, mul_out,
    output acc_out, result, done, term_cnt, busy, ovf, err
  );
endinterface

// File: rtl/mac_accumulator_sat_add.sv
// Combinational signed saturating add of a sign-extended product into an accumulator.
module sat_add
  import mac_pkg::*;
#(
  parameter int ACCW = 20,
  parameter int PW   = 16
) (
  input  logic signed [ACCW-1:0] acc,
  input  logic signed [PW-1:0]   addend,
  output logic signed [ACCW-1:0] sum,
  output logic                   sat
);
  localparam logic signed [ACCW-1:0] MAXV = ACCW'(sat_max(ACCW));
  localparam logic signed [ACCW-1:0] MINV = ACCW'(sat_min(ACCW));

  logic signed [ACCW:0] wide;

  // One extra bit holds the exact sum; disagreeing top bits mean it left range.
  always_comb begin
    wide = {acc[ACCW-1], acc} + {{(ACCW + 1 - PW){addend[PW-1]}}, addend};
    sat  = (wide[ACCW] != wide[ACCW-1]);
    if (!sat)
      sum = wide[ACCW-1:0];
    else if (wide[ACCW])
      sum = MINV;
    else
      sum = MAXV;
  end
endmodule

// File: rtl/mac_accumulator.sv
// Saturating dot-product accumulator trailing a sequential multiplier.
//   state | meaning
//   IDLE  | no product pending; waits for start with mul_ready high
//   WAIT  | product in flight; captures on mul_ready rising, watchdog running
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int OPSIZE  = 8,
  parameter int NTERMS  = 4,
  parameter int GUARD   = 4,
  parameter int TIMEOUT = OPSIZE + 4
) (
  input logic              clk,
  input logic              rst,
  mac_accumulator_if.slave bus
);
  localparam int ACCW = acc_width(OPSIZE, GUARD);
  localparam int PW   = 2 * OPSIZE;
  localparam int CW   = cnt_width(NTERMS);
  localparam int WDW  = $clog2(TIMEOUT + 1);

  mac_state_t             state_q, state_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic                   busy_q;
  logic                   rdy_q;
  logic                   capture;
  logic                   timeout;
  logic                   final_term;
  logic signed [ACCW-1:0] acc_q, result_q, sum;
  logic [CW-1:0]          cnt_q;
  logic                   done_q, ovf_q, err_q, sat;

  sat_add #(.ACCW(ACCW), .PW(PW)) u_sat_add (
    .acc    (acc_q),
    .addend (bus.mul_out),
    .sum    (sum),
    .sat    (sat)
  );

  assign capture    = (state_q == WAIT) && bus.mul_ready && !rdy_q;
  assign final_term = (cnt_q == CW'(NTERMS - 1));

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && bus.mul_ready) begin
          state_d = WAIT;
          wd_d    = '0;
        end
      end
      WAIT: begin
        if (capture) begin
          state_d = IDLE;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          timeout = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      wd_q    <= '0;
    end else if (bus.clr) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == WAIT);
      wd_q    <= wd_d;
    end
  end

  // rdy_q resets high so a ready multiplier out of reset never looks like a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q    <= 1'b1;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdy_q  <= bus.mul_ready;
      done_q <= 1'b0;
      if (bus.clr) begin
        acc_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        if (timeout)
          err_q <= 1'b1;
        if (capture) begin
          if (sat)
            ovf_q <= 1'b1;
          if (final_term) begin
            result_q <= sum;
            done_q   <= 1'b1;
            acc_q    <= '0;
            cnt_q    <= '0;
          end else begin
            acc_q <= sum;
            cnt_q <= cnt_q + CW'(1);
          end
        end
      end
    end
  end

  assign bus.acc_out  = acc_q;
  assign bus.result   = result_q;
  assign bus.done     = done_q;
  assign bus.term_cnt = cnt_q;
  assign bus.busy     = busy_q;
  assign bus.ovf      = ovf_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: directed table, corner sequences, randomized run against a model.
module tb_mac_accumulator;
  localparam int OPSIZE  = 4;
  localparam int NTERMS  = 4;
  localparam int GUARD   = 1;
  localparam int ACCW    = 2 * OPSIZE + GUARD;
  localparam int PW      = 2 * OPSIZE;
  localparam int TIMEOUT = OPSIZE + 4;
  localparam int MAXV    = (1 << (ACCW - 1)) - 1;
  localparam int MINV    = -(1 << (ACCW - 1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_accumulator_if #(.OPSIZE(OPSIZE), .NTERMS(NTERMS), .GUARD(GUARD)) bus ();

  mac_accumulator #(.OPSIZE(OPSIZE), .NTERMS(NTERMS), .GUARD(GUARD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int a;
    int b;
    int acc;
    int cnt;
    int done;
    int res;
    int ovf;
  } vec_t;

  vec_t tbl [8];

  int nvec = 0;
  int nerr = 0;

  // Reference model state: dot-product arithmetic on plain integers.
  int m_acc, m_cnt, m_result, m_ovf, m_err, m_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_acc = 0; m_cnt = 0; m_ovf = 0; m_err = 0; m_done = 0;
  endtask

  task automatic model_absorb(input int p);
    int s;
    s = m_acc + p;
    if (s > MAXV) begin s = MAXV; m_ovf = 1; end
    if (s < MINV) begin s = MINV; m_ovf = 1; end
    if (m_cnt == NTERMS - 1) begin
      m_result = s; m_acc = 0; m_cnt = 0; m_done = 1;
    end else begin
      m_acc = s; m_cnt = m_cnt + 1; m_done = 0;
    end
  endtask

  task automatic check_all(input string tag, input int exp_busy);
    check({tag, "/acc_out"},  bus.acc_out,  m_acc);
    check({tag, "/term_cnt"}, bus.term_cnt, m_cnt);
    check({tag, "/result"},   bus.result,   m_result);
    check({tag, "/done"},     bus.done,     m_done);
    check({tag, "/ovf"},      bus.ovf,      m_ovf);
    check({tag, "/err"},      bus.err,      m_err);
    check({tag, "/busy"},     bus.busy,     exp_busy);
    m_done = 0;
  endtask

  // Behavioural multiplier: ready drops after start, returns OPSIZE+1+extra edges later.
  task automatic run_term(input int a, input int b, input int extra, input bit mid_start);
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.mul_ready = 1'b0;
    check("term/busy_after_start", bus.busy, 1);
    check("term/done_single_cycle", bus.done, 0);
    for (int k = 1; k <= OPSIZE + 1 + extra; k++) begin
      bus.start = (mid_start && k == 2);
      tick();
    end
    bus.start     = 1'b0;
    bus.mul_out   = PW'(a * b);
    bus.mul_ready = 1'b1;
    tick();
    model_absorb(a * b);
  endtask

  task automatic run_timeout(input int hold);
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.mul_ready = 1'b0;
    for (int k = 1; k <= hold; k++) begin
      tick();
      if (k == TIMEOUT - 1) begin
        check("tmo/err_before", bus.err, m_err);
        check("tmo/busy_before", bus.busy, 1);
      end
      if (k == TIMEOUT) begin
        m_err = 1;
        check_all("tmo/abort", 0);
      end
    end
    bus.mul_ready = 1'b1;
    tick();
    check_all("tmo/late_ready", 0);
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    model_clear();
  endtask

  initial begin
    tbl[0] = '{ 4,  6,  24, 1, 0,   0, 0};
    tbl[1] = '{-4,  6,   0, 2, 0,   0, 0};
    tbl[2] = '{ 4, -6, -24, 3, 0,   0, 0};
    tbl[3] = '{-4, -6,   0, 0, 1,   0, 0};
    tbl[4] = '{-8, -8,  64, 1, 0,   0, 0};
    tbl[5] = '{-8, -8, 128, 2, 0,   0, 0};
    tbl[6] = '{-8, -8, 192, 3, 0,   0, 0};
    tbl[7] = '{-8, -8,   0, 0, 1, 255, 1};

    rst = 1'b1;
    bus.clr = 1'b0; bus.start = 1'b0; bus.mul_ready = 1'b1; bus.mul_out = '0;
    m_result = 0;
    model_clear();
    tick();
    tick();
    check_all("reset", 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle/acc_out", bus.acc_out, 0);
      check("idle/busy", bus.busy, 0);
      check("idle/done", bus.done, 0);
    end

    for (int i = 0; i < 8; i++) begin
      run_term(tbl[i].a, tbl[i].b, 0, 1'b0);
      check($sformatf("tbl%0d/acc_out", i),  bus.acc_out,  tbl[i].acc);
      check($sformatf("tbl%0d/term_cnt", i), bus.term_cnt, tbl[i].cnt);
      check($sformatf("tbl%0d/done", i),     bus.done,     tbl[i].done);
      check($sformatf("tbl%0d/result", i),   bus.result,   tbl[i].res);
      check($sformatf("tbl%0d/ovf", i),      bus.ovf,      tbl[i].ovf);
      check($sformatf("tbl%0d/busy", i),     bus.busy,     0);
      m_done = 0;
    end

    run_term(1, 1, 0, 1'b0);
    check_all("ovf_sticky", 0);
    pulse_clr();
    check_all("ovf_clr", 0);

    run_term(4, 6, 0, 1'b0);
    run_term(4, 6, 1, 1'b0);
    check_all("pre_clr", 0);
    pulse_clr();
    check_all("post_clr", 0);
    for (int i = 0; i < NTERMS; i++) begin
      run_term(1, 1, 0, 1'b0);
      check_all("ones", 0);
    end
    check("ones/result4", bus.result, 4);

    run_term(2, 3, 0, 1'b0);
    check_all("pre_tmo", 0);
    run_timeout(20);
    for (int i = 0; i < NTERMS - 1; i++) begin
      run_term(-3, 5, 2, 1'b0);
      check_all("post_tmo", 0);
    end
    pulse_clr();

    bus.mul_ready = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_all("start_not_ready", 0);
    bus.mul_ready = 1'b1;
    tick();
    tick();
    check_all("start_not_ready_after", 0);
    run_term(3, 5, 0, 1'b1);
    check_all("mid_start", 0);
    repeat (OPSIZE + 4) tick();
    check_all("mid_start_quiet", 0);

    for (int i = 0; i < 60; i++) begin
      int a, b, extra, gap, sel;
      a     = int'($urandom_range(15)) - 8;
      b     = int'($urandom_range(15)) - 8;
      extra = int'($urandom_range(2));
      gap   = int'($urandom_range(2));
      sel   = int'($urandom_range(19));
      repeat (gap) tick();
      if (sel == 0) begin
        pulse_clr();
        check_all("rnd_clr", 0);
      end else if (sel < 3) begin
        run_timeout(TIMEOUT + int'($urandom_range(3)));
      end else begin
        run_term(a, b, extra, sel == 3);
        check_all("rnd_term", 0);
      end
    end

    tick();
    check("end/done_low", bus.done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
